// File: rtl/drop_timing_source_pkg.sv
// Shared constants for the drop timing producer: FSM encoding and fixed-point widths.
// Used by drop_timing_source (optional SENSOR_FAULT_FILTER_EN build) and seq_sqrt.
package drop_timing_source_pkg;

   localparam int FIXED_W = 16;
   localparam int RAD_W   = 24;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_AVG  = 2'd1;
   localparam logic [1:0] ST_SQRT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/drop_timing_source_seq_sqrt.sv
// Sequential restoring integer square root, one root bit per cycle, MSB first.
// The first iteration is taken on the start edge, so done_o rises ITER cycles after start_i.
module seq_sqrt
   import drop_timing_source_pkg::*;
#(
   parameter int ITER = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [RAD_W-1:0] radicand_i,
   output logic             done_o,
   output logic [ITER-1:0]  root_o
);

   localparam int EXT_W = 2 * ITER;
   localparam int REM_W = ITER + 4;
   localparam int CNT_W = $clog2(ITER + 1);

   logic [EXT_W-1:0] radExt;
   logic [EXT_W-1:0] rad_q, rad_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [ITER-1:0]  root_q, root_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             running_q, running_d;

   logic [1:0]       pair;
   logic [REM_W-1:0] remIn, remShift, trial, remStep;
   logic [ITER-1:0]  rootIn, rootStep;

   assign radExt = {{(EXT_W - RAD_W){1'b0}}, radicand_i};

   always_comb begin
      pair     = start_i ? radExt[EXT_W-1 -: 2] : rad_q[EXT_W-1 -: 2];
      remIn    = start_i ? '0 : rem_q;
      rootIn   = start_i ? '0 : root_q;
      remShift = (remIn << 2) | REM_W'(pair);
      trial    = {2'b00, rootIn, 2'b01};
      if (remShift >= trial) begin
         remStep  = remShift - trial;
         rootStep = (rootIn << 1) | ITER'(1);
      end else begin
         remStep  = remShift;
         rootStep = rootIn << 1;
      end
   end

   always_comb begin
      rad_d     = rad_q;
      rem_d     = rem_q;
      root_d    = root_q;
      cnt_d     = cnt_q;
      running_d = running_q;
      if (start_i) begin
         rad_d     = radExt << 2;
         rem_d     = remStep;
         root_d    = rootStep;
         cnt_d     = CNT_W'(ITER - 1);
         running_d = 1'b1;
      end else if (running_q) begin
         if (cnt_q != '0) begin
            rad_d  = rad_q << 2;
            rem_d  = remStep;
            root_d = rootStep;
            cnt_d  = cnt_q - CNT_W'(1);
         end else begin
            running_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rad_q     <= '0;
         rem_q     <= '0;
         root_q    <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
      end else begin
         rad_q     <= rad_d;
         rem_q     <= rem_d;
         root_q    <= root_d;
         cnt_q     <= cnt_d;
         running_q <= running_d;
      end
   end

   assign done_o = running_q && (cnt_q == '0);
   assign root_o = root_q;

endmodule

// File: rtl/drop_timing_source.sv
// Drop timing producer: averages four height sensors, takes sqrt(h) in 8.8 and presents a registered bundle.
// Define SENSOR_FAULT_FILTER_EN to drop a sensor pair that reports a zero reading.
module drop_timing_source
   import drop_timing_source_pkg::*;
#(
   parameter int SQRT_ITER = 16,
   parameter int SENS_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SENS_W-1:0]  sensor1,
   input  logic [SENS_W-1:0]  sensor2,
   input  logic [SENS_W-1:0]  sensor3,
   input  logic [SENS_W-1:0]  sensor4,
   input  logic               sample_valid,
   input  logic [FIXED_W-1:0] t_lim_in,
   input  logic               drop_req,
   output logic [FIXED_W-1:0] t_act,
   output logic [FIXED_W-1:0] t_lim,
   output logic               drop_en,
   output logic               result_valid,
   output logic               busy
);

   logic [1:0]         state_q, state_d;
   logic [SENS_W-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
   logic [FIXED_W-1:0] limCap_q, limCap_d;
   logic               dropCap_q, dropCap_d;
   logic [FIXED_W-1:0] tAct_q, tAct_d, tLim_q, tLim_d;
   logic               dropEn_q, dropEn_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;

   logic [SENS_W+1:0]  sum4;
   logic [SENS_W-1:0]  height;
   logic [RAD_W-1:0]   radicand;
   logic               sqrtStart;
   logic               sqrtDone;
   logic [SQRT_ITER-1:0] sqrtRoot;

   // Height is derived from the captured samples, so later sensor changes cannot disturb a conversion.
   assign sum4 = {2'b00, s1_q} + {2'b00, s2_q} + {2'b00, s3_q} + {2'b00, s4_q}
               + (SENS_W + 2)'(2);

`ifdef SENSOR_FAULT_FILTER_EN
   logic [SENS_W:0] sum24, sum13;
   assign sum24 = {1'b0, s2_q} + {1'b0, s4_q} + (SENS_W + 1)'(1);
   assign sum13 = {1'b0, s1_q} + {1'b0, s3_q} + (SENS_W + 1)'(1);

   always_comb begin
      if (((s1_q == '0) || (s3_q == '0)) && ((s2_q == '0) || (s4_q == '0)))
         height = '0;
      else if ((s1_q == '0) || (s3_q == '0))
         height = SENS_W'(sum24 >> 1);
      else if ((s2_q == '0) || (s4_q == '0))
         height = SENS_W'(sum13 >> 1);
      else
         height = SENS_W'(sum4 >> 2);
   end
`else
   assign height = SENS_W'(sum4 >> 2);
`endif

   assign radicand  = {height, 16'h0000};
   assign sqrtStart = (state_q == ST_AVG);

   seq_sqrt #(.ITER(SQRT_ITER)) u_sqrt (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (sqrtStart),
      .radicand_i (radicand),
      .done_o     (sqrtDone),
      .root_o     (sqrtRoot)
   );

   // Outputs are loaded on the SQRT->DONE edge so result_valid is visible throughout DONE.
   always_comb begin
      state_d   = state_q;
      s1_d      = s1_q;
      s2_d      = s2_q;
      s3_d      = s3_q;
      s4_d      = s4_q;
      limCap_d  = limCap_q;
      dropCap_d = dropCap_q;
      tAct_d    = tAct_q;
      tLim_d    = tLim_q;
      dropEn_d  = dropEn_q;
      valid_d   = 1'b0;
      busy_d    = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (sample_valid) begin
               s1_d      = sensor1;
               s2_d      = sensor2;
               s3_d      = sensor3;
               s4_d      = sensor4;
               limCap_d  = t_lim_in;
               dropCap_d = drop_req;
               busy_d    = 1'b1;
               state_d   = ST_AVG;
            end
         end
         ST_AVG: begin
            state_d = ST_SQRT;
         end
         ST_SQRT: begin
            if (sqrtDone) begin
               tAct_d   = FIXED_W'(sqrtRoot);
               tLim_d   = limCap_q;
               dropEn_d = dropCap_q;
               valid_d  = 1'b1;
               state_d  = ST_DONE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         s4_q      <= '0;
         limCap_q  <= '0;
         dropCap_q <= 1'b0;
         tAct_q    <= '0;
         tLim_q    <= '0;
         dropEn_q  <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         s3_q      <= s3_d;
         s4_q      <= s4_d;
         limCap_q  <= limCap_d;
         dropCap_q <= dropCap_d;
         tAct_q    <= tAct_d;
         tLim_q    <= tLim_d;
         dropEn_q  <= dropEn_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign t_act        = tAct_q;
   assign t_lim        = tLim_q;
   assign drop_en      = dropEn_q;
   assign result_valid = valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_drop_timing_source.sv
// Scoreboard bench for drop_timing_source: directed requests, ignored samples, mid-conversion reset, back-to-back.
module tb_drop_timing_source;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  sensor1, sensor2, sensor3, sensor4;
   logic        sample_valid;
   logic [15:0] t_lim_in;
   logic        drop_req;
   logic [15:0] t_act, t_lim;
   logic        drop_en, result_valid, busy;

   typedef struct packed {
      logic [15:0] tAct;
      logic [15:0] tLim;
      logic        dropEn;
   } expT;

   expT sbQueue[$];
   expT lastExp = '0;
   int  checks = 0;
   int  passed = 0;

   always #5 clk = ~clk;

   drop_timing_source dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sensor1      (sensor1),
      .sensor2      (sensor2),
      .sensor3      (sensor3),
      .sensor4      (sensor4),
      .sample_valid (sample_valid),
      .t_lim_in     (t_lim_in),
      .drop_req     (drop_req),
      .t_act        (t_act),
      .t_lim        (t_lim),
      .drop_en      (drop_en),
      .result_valid (result_valid),
      .busy         (busy)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed = passed + 1;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] modelH(input logic [7:0] a, b, c, d);
      int s;
`ifdef SENSOR_FAULT_FILTER_EN
      if ((a == 0 || c == 0) && (b == 0 || d == 0)) return 8'd0;
      if (a == 0 || c == 0) return 8'((int'(b) + int'(d) + 1) / 2);
      if (b == 0 || d == 0) return 8'((int'(a) + int'(c) + 1) / 2);
`endif
      s = int'(a) + int'(b) + int'(c) + int'(d) + 2;
      return 8'(s / 4);
   endfunction

   function automatic logic [15:0] modelSqrt(input logic [7:0] h);
      int r;
      int q;
      r = int'(h) * 65536;
      q = 0;
      while ((q + 1) * (q + 1) <= r) q++;
      return 16'(q);
   endfunction

   function automatic expT modelExp(input logic [7:0] a, b, c, d, input logic [15:0] tl, input logic dr);
      expT e;
      e.tAct   = modelSqrt(modelH(a, b, c, d));
      e.tLim   = tl;
      e.dropEn = dr;
      return e;
   endfunction

   // Pops the scoreboard on every result and otherwise demands the last result is still held.
   initial begin
      logic rstSeen;
      expT  e;
      forever begin
         @(posedge clk);
         rstSeen = rst_n;
         #1;
         if (!rstSeen) begin
            lastExp = '0;
         end else if (result_valid === 1'b1) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected_result_valid", 64'(result_valid), 64'd0);
            end else begin
               e = sbQueue.pop_front();
               checkOutput("t_act", 64'(t_act), 64'(e.tAct));
               checkOutput("t_lim", 64'(t_lim), 64'(e.tLim));
               checkOutput("drop_en", 64'(drop_en), 64'(e.dropEn));
               lastExp = e;
            end
         end else begin
            checkOutput("hold_outputs", 64'({t_act, t_lim, drop_en}), 64'(lastExp));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] a, b, c, d, input logic [15:0] tl, input logic dr);
      sensor1      = a;
      sensor2      = b;
      sensor3      = c;
      sensor4      = d;
      t_lim_in     = tl;
      drop_req     = dr;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   // Called in the cycle after the accept edge; counts that as cycle 1 of the latency.
   task automatic waitResult(input string tag, input int expLat, input bit inject);
      int cycles = 1;
      bit busyOk = 1'b1;
      while (result_valid !== 1'b1 && cycles < 40) begin
         if (busy !== 1'b1) busyOk = 1'b0;
         if (inject) begin
            if (cycles == 5 || cycles == 10) begin
               sample_valid = 1'b1;
               sensor1 = 8'd200; sensor2 = 8'd201; sensor3 = 8'd202; sensor4 = 8'd203;
               t_lim_in = 16'hDEAD;
               drop_req = 1'b0;
            end else begin
               sample_valid = 1'b0;
            end
         end
         @(posedge clk); #1;
         cycles++;
      end
      if (busy !== 1'b1) busyOk = 1'b0;
      checkOutput({tag, "_latency"}, 64'(cycles), 64'(expLat));
      checkOutput({tag, "_busy"}, 64'(busyOk), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic expectQuiet(input string tag, input int n);
      bit quiet = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (result_valid !== 1'b0) quiet = 1'b0;
         @(posedge clk); #1;
      end
      checkOutput(tag, 64'(quiet), 64'd1);
   endtask

   initial begin
      logic [7:0] ra, rb, rc, rd;
      logic [15:0] rl;
      rst_n = 1'b0;
      sensor1 = '0; sensor2 = '0; sensor3 = '0; sensor4 = '0;
      sample_valid = 1'b0;
      t_lim_in = '0;
      drop_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_t_act", 64'(t_act), 64'd0);
      checkOutput("reset_t_lim", 64'(t_lim), 64'd0);
      checkOutput("reset_drop_en", 64'(drop_en), 64'd0);
      checkOutput("reset_result_valid", 64'(result_valid), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      sbQueue.push_back('{tAct: 16'h0A00, tLim: 16'h0B00, dropEn: 1'b1});
      applyStimulus(8'd100, 8'd100, 8'd100, 8'd100, 16'h0B00, 1'b1);
      waitResult("all100", 18, 1'b0);

      sbQueue.push_back('{tAct: 16'h016A, tLim: 16'h1234, dropEn: 1'b0});
      applyStimulus(8'd2, 8'd2, 8'd2, 8'd2, 16'h1234, 1'b0);
      waitResult("all2", 18, 1'b0);

      sbQueue.push_back('{tAct: 16'h0000, tLim: 16'hFFFF, dropEn: 1'b1});
      applyStimulus(8'd0, 8'd0, 8'd0, 8'd0, 16'hFFFF, 1'b1);
      waitResult("all0", 18, 1'b0);

      sbQueue.push_back('{tAct: 16'h0FF7, tLim: 16'h0102, dropEn: 1'b0});
      applyStimulus(8'd255, 8'd255, 8'd255, 8'd255, 16'h0102, 1'b0);
      waitResult("all255", 18, 1'b0);

`ifdef SENSOR_FAULT_FILTER_EN
      sbQueue.push_back('{tAct: 16'h0712, tLim: 16'h0300, dropEn: 1'b1});
`else
      sbQueue.push_back('{tAct: 16'h06B5, tLim: 16'h0300, dropEn: 1'b1});
`endif
      applyStimulus(8'd0, 8'd50, 8'd80, 8'd50, 16'h0300, 1'b1);
      waitResult("fault_s1", 18, 1'b0);

      $display("[TB] sample_valid while busy must be ignored");
      sbQueue.push_back(modelExp(8'd30, 8'd30, 8'd30, 8'd30, 16'h0444, 1'b1));
      applyStimulus(8'd30, 8'd30, 8'd30, 8'd30, 16'h0444, 1'b1);
      waitResult("ignore_busy", 18, 1'b1);
      expectQuiet("ignore_no_second_result", 25);

      $display("[TB] reset in the middle of SQRT");
      sbQueue.push_back(modelExp(8'd77, 8'd77, 8'd77, 8'd77, 16'h0555, 1'b1));
      applyStimulus(8'd77, 8'd77, 8'd77, 8'd77, 16'h0555, 1'b1);
      repeat (8) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sbQueue.delete();
      checkOutput("midreset_outputs", 64'({t_act, t_lim, drop_en}), 64'd0);
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      checkOutput("midreset_valid", 64'(result_valid), 64'd0);
      expectQuiet("midreset_no_result", 25);
      sbQueue.push_back(modelExp(8'd64, 8'd64, 8'd64, 8'd64, 16'h0666, 1'b0));
      applyStimulus(8'd64, 8'd64, 8'd64, 8'd64, 16'h0666, 1'b0);
      waitResult("after_reset", 18, 1'b0);

      $display("[TB] back-to-back with sample_valid held high");
      sbQueue.push_back(modelExp(8'd120, 8'd120, 8'd120, 8'd120, 16'h0100, 1'b1));
      sbQueue.push_back(modelExp(8'd60, 8'd61, 8'd62, 8'd63, 16'h0200, 1'b0));
      sensor1 = 8'd120; sensor2 = 8'd120; sensor3 = 8'd120; sensor4 = 8'd120;
      t_lim_in = 16'h0100;
      drop_req = 1'b1;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sensor1 = 8'd60; sensor2 = 8'd61; sensor3 = 8'd62; sensor4 = 8'd63;
      t_lim_in = 16'h0200;
      drop_req = 1'b0;
      waitResult("b2b_first", 18, 1'b0);
      checkOutput("b2b_idle_gap_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      checkOutput("b2b_second_accepted", 64'(busy), 64'd1);
      waitResult("b2b_second", 18, 1'b0);

      for (int i = 0; i < 3; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 8'($urandom_range(0, 255));
         rd = 8'($urandom_range(0, 255));
         rl = 16'($urandom);
         sbQueue.push_back(modelExp(ra, rb, rc, rd, rl, 1'(i)));
         applyStimulus(ra, rb, rc, rd, rl, 1'(i));
         waitResult("random", 18, 1'b0);
      end

      repeat (3) begin @(posedge clk); #1; end
      checkOutput("scoreboard_empty", 64'(sbQueue.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/drop_timing_source.md
Name: drop_timing_source

Overview:
Producer side of the display/drop interface. Samples four height sensors and computes the fall time `t_act` as a sequential fixed-point square root of the height. It latches `t_lim` and the drop request alongside the result, then presents `t_act`, `t_lim` and `drop_en` to `display_and_drop` as a stable registered bundle with a valid strobe.

Parameters:
- SQRT_ITER, 16: square-root iterations; one result bit per cycle; result is 8.8 fixed point.
- SENS_W, 8: width of each sensor input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- sensor1..sensor4  in  SENS_W each  height readings; 0 = faulty sensor.
- sample_valid  in  1  request to start a conversion; accepted only in IDLE.
- t_lim_in  in  16  limit time, 8.8 fixed point.
- drop_req  in  1  operator drop request.
- t_act  out  16  computed time, 8.8 fixed point, unsigned.
- t_lim  out  16  `t_lim_in` captured at accept.
- drop_en  out  1  `drop_req` captured at accept.
- result_valid  out  1  one-cycle pulse when the outputs update.
- busy  out  1  high from the accept cycle until `result_valid`, inclusive.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. All internal registers are cleared. Reset in any state, including mid-SQRT, aborts the conversion with no `result_valid`.
- FSM IDLE → AVG → SQRT → DONE → IDLE.
- IDLE:
  - If `sample_valid`=1: capture the sensors, `t_lim_in` and `drop_req` into internal registers, raise `busy`, go to AVG.
  - Otherwise hold.
- AVG (1 cycle): compute height h (SENS_W bits) per the averaging rule. Load the square-root radicand R = {h, 16'h0000}, i.e. 24 bits of h<<16.
- SQRT (SQRT_ITER cycles): restoring bit-by-bit integer square root of R, one bit per cycle, MSB first. Result q = floor(sqrt(R)), which is sqrt(h) in 8.8 format, truncated (no rounding).
- DONE (1 cycle):
  - Register `t_act`=q, `t_lim` and `drop_en` from the captured values.
  - Pulse `result_valid`=1 and drop `busy` at the end of this cycle.
  - Go to IDLE.
- Latency: `sample_valid` accepted in cycle N → `result_valid` high in cycle N+SQRT_ITER+2 (N+18 by default).
- `t_act`, `t_lim` and `drop_en` hold their values between DONE cycles. They never change while `result_valid`=0.
- `sample_valid` while `busy`=1 is ignored (no queueing). Input changes after accept have no effect on the running conversion.
- Default averaging (baseline): h = (s1+s2+s3+s4+2)>>2, with a 10-bit intermediate and round-half-up.
- h=0 gives `t_act`=0. h=255 gives `t_act`=0x0FF7 (floor(sqrt(255)*256)).

Optional Feature:
- Macro SENSOR_FAULT_FILTER_EN.
- Defined: fault-aware averaging replaces the default.
  - If s1==0 or s3==0: h=(s2+s4+1)>>1.
  - Else if s2==0 or s4==0: h=(s1+s3+1)>>1.
  - Else: the default four-sensor average.
  - If both pairs contain a zero, h=0.
- Not defined: the plain four-sensor rounded average is always used, and zeros are treated as valid readings.

Decomposition:
- Shared package: FSM state encoding (IDLE/AVG/SQRT/DONE, 2 bits), the 8.8 fixed-point width constant (16), and the radicand width constant (24).
- Sub-module `seq_sqrt`: start/done handshake, 24-bit radicand in, 16-bit root out, one bit per cycle. It is reusable by other timing blocks. The top level holds the FSM, the averaging logic and the output registers.

Test Plan:
- Reset, then all sensors=100, `t_lim_in`=0x0B00, `drop_req`=1, one-cycle `sample_valid` → `result_valid` exactly 18 cycles later; `t_act`=0x0A00, `t_lim`=0x0B00, `drop_en`=1.
- All sensors=2 → h=2, `t_act`=0x016A. All sensors=0 → `t_act`=0x0000.
- s1=0, s2=50, s3=80, s4=50:
  - With SENSOR_FAULT_FILTER_EN: `t_act`=0x0712 (h=50).
  - Without: `t_act`=0x06B5 (h=45).
- `sample_valid` pulsed at cycles 5 and 10 after the first accept, with different sensor values → single `result_valid`; outputs reflect the first sample only; `busy` stays high throughout.
- Assert `rst_n`=0 for one cycle mid-SQRT → no `result_valid`; all outputs 0. A new request afterwards completes normally in 18 cycles.
- Back-to-back requests with `sample_valid` held high: second accept happens on the cycle after `result_valid`. The first result's outputs stay stable until the second DONE.
